// File: rtl/pooling_average_readout.sv
// Drains NUM_CH per-channel sums from the pooling accumulator BRAM, scales each by RECIP and
// streams four packed 8-bit averages per word. Define POOL_ROUND_EN for round-half-up scaling.
module pooling_average_readout #(
    parameter int unsigned NUM_CH      = 128,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned SUM_W       = 32,
    parameter int unsigned RECIP       = 334,
    parameter int unsigned RECIP_SHIFT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [SUM_W-1:0]  rd_data,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CH_W   = $clog2(NUM_CH);
    localparam int unsigned PROD_W = SUM_W + 17;

    typedef enum logic [2:0] {StIdle, StRd, StCap, StOut, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CH_W-1:0]   ch_q, ch_d, ch_inc;
    logic [31:0]       pack_q, pack_d;

    logic [PROD_W-1:0] prod, scaled;
    logic [7:0]        avg;

    always_comb begin
        prod = PROD_W'(rd_data) * PROD_W'(RECIP);
`ifdef POOL_ROUND_EN
        prod = prod + (PROD_W'(1) << (RECIP_SHIFT - 1));
`endif
        scaled = prod >> RECIP_SHIFT;
        // Anything above 8 bits saturates rather than wrapping.
        avg = (|scaled[PROD_W-1:8]) ? 8'hFF : scaled[7:0];
    end

    // ch returns to 0 after the final channel, which also marks the last word in OUT.
    assign ch_inc = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        ch_d      = ch_q;
        pack_d    = pack_q;
        rd_addr_d = rd_addr_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d    = base_addr;
                    ch_d      = '0;
                    rd_addr_d = base_addr;
                    state_d   = StRd;
                end
            end
            StRd: state_d = StCap;
            StCap: begin
                pack_d[{ch_q[1:0], 3'b000} +: 8] = avg;
                ch_d = ch_inc;
                if (ch_q[1:0] == 2'd3) begin
                    state_d = StOut;
                end else begin
                    rd_addr_d = base_q + ADDR_W'(ch_inc);
                    state_d   = StRd;
                end
            end
            StOut: begin
                if (out_ready) begin
                    if (ch_q == '0) begin
                        state_d = StDone;
                    end else begin
                        rd_addr_d = base_q + ADDR_W'(ch_q);
                        state_d   = StRd;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            base_q    <= '0;
            rd_addr_q <= '0;
            ch_q      <= '0;
            pack_q    <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            rd_addr_q <= rd_addr_d;
            ch_q      <= ch_d;
            pack_q    <= pack_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign out_data  = pack_q;
    assign out_valid = (state_q == StOut);
    assign out_last  = (state_q == StOut) && (ch_q == '0);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_pooling_average_readout.sv
// Directed scoreboard bench for pooling_average_readout (NUM_CH=128 build).
module tb_pooling_average_readout;

    localparam int unsigned NUM_CH = 128;
    localparam int unsigned NWORDS = NUM_CH / 4;
`ifdef POOL_ROUND_EN
    localparam logic [31:0] EXP_W0    = 32'h281E140A;
    localparam logic [7:0]  EXP_19600 = 8'h64;
`else
    localparam logic [31:0] EXP_W0    = 32'h271D1309;
    localparam logic [7:0]  EXP_19600 = 8'h63;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } word_t;

    logic        clk, reset_n, start, out_valid, out_ready, out_last, busy, done;
    logic [31:0] base_addr, rd_addr, rd_data, out_data;

    logic [31:0] mem [256];
    word_t       exp_word[$];
    logic [31:0] exp_addr[$];
    logic [31:0] addr_prev;
    logic        addr_prev_v;
    logic        pend_done;
    int          words_seen;
    int          checks;
    int          failures;

    pooling_average_readout #(.NUM_CH(NUM_CH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model with one cycle of read latency.
    always @(posedge clk) rd_data <= mem[rd_addr[7:0]];

    function automatic logic [7:0] avg_of(input logic [31:0] s);
        logic [63:0] p;
        p = 64'(s) * 64'd334;
`ifdef POOL_ROUND_EN
        p = p + 64'd32768;
`endif
        p = p >> 16;
        return (p > 64'd255) ? 8'hFF : p[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Observe the cycle just before the edge, then advance one clock.
    task automatic step();
        word_t w;
        if (busy === 1'b1) begin
            if (!addr_prev_v || rd_addr !== addr_prev) begin
                if (exp_addr.size() == 0) begin
                    check("addr_extra", rd_addr, 32'hDEAD_BEEF);
                end else begin
                    check("rd_addr", rd_addr, exp_addr.pop_front());
                end
            end
            addr_prev   = rd_addr;
            addr_prev_v = 1'b1;
        end else begin
            addr_prev_v = 1'b0;
        end
        if (pend_done || done === 1'b1) check("done", 32'(done), 32'(pend_done));
        pend_done = 1'b0;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_word.size() == 0) begin
                check("word_extra", out_data, 32'hDEAD_BEEF);
            end else begin
                w = exp_word.pop_front();
                check("out_data", out_data, w.data);
                check("out_last", 32'(out_last), 32'(w.last));
                pend_done = w.last;
            end
            words_seen++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_drain(input logic [31:0] b);
        logic [31:0] a;
        word_t w;
        for (int k = 0; k < int'(NWORDS); k++) begin
            for (int j = 0; j < 4; j++) begin
                a = b + 32'(4 * k + j);
                exp_addr.push_back(a);
                w.data[8*j +: 8] = avg_of(mem[a[7:0]]);
            end
            w.last = (k == int'(NWORDS) - 1);
            exp_word.push_back(w);
        end
        words_seen = 0;
        base_addr  = b;
        start      = 1'b1;
        step();
        start      = 1'b0;
        base_addr  = 32'h0;
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic run_to_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic drain_complete();
        check("words", 32'(words_seen), 32'(NWORDS));
        check("addr_left", 32'(exp_addr.size()), 32'd0);
        check("word_left", 32'(exp_word.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        checks = 0; failures = 0; words_seen = 0;
        pend_done = 1'b0; addr_prev_v = 1'b0; addr_prev = '0;
        reset_n = 1'b0; start = 1'b0; out_ready = 1'b1; base_addr = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom_range(0, 70000);
        mem[8'h40] = 32'd1960;  mem[8'h41] = 32'd3920;
        mem[8'h42] = 32'd5880;  mem[8'h43] = 32'd7840;
        mem[8'h44] = 32'd19600; mem[8'h46] = 32'hFFFF_FFFF;
        for (int i = 8'h48; i < 8'h4C; i++) mem[i] = 32'd0;

        repeat (3) @(negedge clk);
        check("rst_rd_addr", rd_addr, 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_ctrl", {28'h0, out_valid, out_last, busy, done}, 32'h0);
        reset_n = 1'b1;
        step();

        // Drain 1: base 0x40, latency, constant lanes, stall on word 3, ignored restart.
        start_drain(32'h40);
        check("busy", 32'(busy), 32'd1);
        repeat (7) step();
        check("latency_pre", 32'(out_valid), 32'd0);
        step();
        check("latency_valid", 32'(out_valid), 32'd1);
        check("word0_const", out_data, EXP_W0);
        step();
        wait_valid(20);
        check("avg_19600", 32'(out_data[7:0]), 32'(EXP_19600));
        check("sat_lane2", 32'(out_data[23:16]), 32'hFF);
        step();
        wait_valid(20);
        check("word0_zero_sum_next", 32'(words_seen), 32'd2);
        step();
        out_ready = 1'b0;
        wait_valid(20);
        held = out_data;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", out_data, held);
            check("stall_last", 32'(out_last), 32'd0);
        end
        out_ready = 1'b1;
        repeat (10) step();
        base_addr = 32'h99;
        start     = 1'b1;
        step();
        start     = 1'b0;
        base_addr = 32'h0;
        run_to_done(400);
        start     = 1'b1;
        base_addr = 32'h77;
        step();
        start     = 1'b0;
        check("start_in_done", 32'(busy), 32'd0);
        step();
        check("idle_after", {30'h0, busy, out_valid}, 32'h0);
        drain_complete();

        // Drain 2: asynchronous reset during OUT of word 2.
        start_drain(32'h10);
        begin
            int n;
            n = 0;
            while (!(words_seen == 2 && out_valid === 1'b1) && n < 100) begin
                step();
                n++;
            end
            check("reach_word2", 32'(words_seen), 32'd2);
        end
        reset_n = 1'b0;
        #1;
        check("arst_out_data", out_data, 32'h0);
        check("arst_rd_addr", rd_addr, 32'h0);
        check("arst_ctrl", {28'h0, out_valid, out_last, busy, done}, 32'h0);
        exp_word.delete();
        exp_addr.delete();
        pend_done = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            step();
            check("arst_no_done", 32'(done), 32'd0);
        end
        reset_n = 1'b1;
        step();

        // Drain 3: fresh start from channel 0 with address wrap-around.
        start_drain(32'hFFFF_FFF0);
        run_to_done(400);
        step();
        drain_complete();
        check("final_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pooling_average_readout.md
Name: pooling_average_readout

Overview:
- Drain engine for the global-average-pooling accumulator BRAM.
- Walks NUM_CH per-channel 32-bit sums through the BRAM read port and scales each sum by a fixed-point reciprocal to get the 8-bit average.
- Packs four averages per 32-bit word, lane order matching the accumulator's byte unpacking, and streams the words to the next layer's IFM buffer over a valid/ready handshake.

Parameters:
- NUM_CH, 128, number of channels to drain; must be a multiple of 4.
- ADDR_W, 32, BRAM address width.
- SUM_W, 32, width of one accumulated sum.
- RECIP, 334, reciprocal of the pooling window in Q0.16 (65536/196 for 14x14).
- RECIP_SHIFT, 16, right shift applied after the multiply.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a drain; ignored while busy.
- base_addr  in  ADDR_W  BRAM address of channel 0; latched on start.
- rd_addr  out  ADDR_W  BRAM read address (registered).
- rd_data  in  SUM_W  BRAM read data; 1-cycle read latency.
- out_data  out  32  packed averages; channel 4k+j in bits [8j+7:8j].
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  marks the final word of the drain.
- busy  out  1  high from start accepted until DONE exits.
- done  out  1  one-cycle pulse at drain completion.

Behaviour:
- Reset: all outputs 0, state IDLE, channel counter 0, pack register 0. Reset is asynchronous and applies mid-operation; the drain is abandoned and no done pulse is produced.
- States: IDLE, RD, CAP, OUT, DONE.
- IDLE:
  - On start=1: latch base_addr, ch=0, busy=1, set rd_addr=base_addr, go to RD.
- RD:
  - rd_addr holds base+ch for the whole cycle. Go to CAP.
- CAP:
  - rd_data is valid this cycle.
  - avg = (rd_data*RECIP) >> RECIP_SHIFT, using a product of at least SUM_W+16 bits. Saturate avg to 255 if it exceeds 8 bits.
  - Write avg into lane ch[1:0] of the pack register, then ch++.
  - If ch[1:0] was 3: go to OUT. Otherwise load rd_addr=base+ch (the incremented ch) and go to RD.
- OUT:
  - out_valid=1; out_data=pack register.
  - out_last=1 iff this word holds channels NUM_CH-4..NUM_CH-1.
  - out_data and out_last are stable while out_ready=0; no timeout.
  - On out_valid&out_ready:
    - Clear out_valid.
    - If last: go to DONE.
    - Else: load rd_addr=base+ch and go to RD.
- DONE:
  - done=1 for exactly one cycle; busy drops to 0 on the same edge that leaves DONE. Go to IDLE.
- Latency:
  - Start sampled at edge E0; first out_valid is high in the cycle after edge E8 (4×RD/CAP pairs).
  - Each subsequent word takes 8 cycles plus any stall cycles.
- Throughput: 1 channel per 2 cycles; the pipeline stalls only in OUT.
- Boundaries:
  - start during busy: ignored; base is not relatched.
  - start coincident with the DONE cycle: ignored.
  - Address arithmetic wraps modulo 2^ADDR_W.
  - ch wraps to 0 after the drain.
  - Sum = 0 gives avg 0.
  - A sum large enough to exceed 255 after scaling is saturated, never wrapped.
- The block never writes the BRAM. The accumulator must not be in its accumulate phase while busy=1; that is a system-level rule, not checked here.

Optional Feature:
- Macro POOL_ROUND_EN.
- Defined: avg = (rd_data*RECIP + 2^(RECIP_SHIFT-1)) >> RECIP_SHIFT (round half up), then the same saturation.
- Undefined: truncation as described above.
- Latency and handshake are identical in both builds.

Test Plan:
- Sums 196×{10,20,30,40} at base 0x40, NUM_CH=4, out_ready=1, start at cycle 0:
  - rd_addr sequence 0x40..0x43.
  - Single word out_data=0x27_1D_13_09 with out_last=1, done one cycle after the handshake.
  - With POOL_ROUND_EN: out_data=0x28_1E_14_0A.
- Sum 19600 (avg 100): result 99 (0x63) truncated; 100 (0x64) with POOL_ROUND_EN.
- Sum 0xFFFFFFFF in lane 2: that byte is 0xFF; the other lanes are unaffected.
- NUM_CH=128 with out_ready low for 5 cycles on word 3:
  - out_data is stable during the stall; exactly 32 words are transferred.
  - out_last only on word 31; addresses are contiguous and none are skipped or repeated.
- start pulsed again mid-drain with a different base_addr: ignored; the addresses continue from the original base.
- reset_n low during OUT of word 2:
  - Outputs return to 0 immediately and no done pulse appears.
  - A fresh start afterwards restarts at channel 0.
